seg7_reader: RTL

Receive-side counterpart of the hex-to-seven-segment decoder. The block watches a multiplexed, active-low seven-segment bus (segment pattern plus one-hot digit strobe), filters out glitches, and converts each stable pattern back into a 4-bit hex nibble. The nibble is stored in a per-digit slot. It serves as a loopback checker and display monitor next to the display driver, so a bench or host can read back what the panel is actually showing.

---
 rtl/seg7_reader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seg7_reader.sv
// seg7_reader
//   Watches a multiplexed, active-low seven-segment bus and turns each stable
//   pattern back into a hex nibble. The nibble is stored in the slot of the
//   strobed digit. Glitches are filtered by requiring the same
//   {seg, dig_sel} sample for STABLE_CYCLES consecutive compares.
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous, active-high reset
//   seg          : segment pattern, active-low, bit6 = g ... bit0 = a
//   dig_sel      : active-high digit strobe, expected one-hot
//   clr          : synchronous clear of digit_valid and err_count
//   value        : decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  : slot i holds a valid decoded nibble
//   update       : one-cycle pulse when a slot is written or blanked
//   err          : one-cycle pulse on a rejected pattern or strobe
//   err_count    : saturating count of err pulses
//
// Output pulses: update and err are plain one-cycle strobes with no
// handshake. A consumer must sample them every cycle. They are mutually
// exclusive.
module seg7_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  update,
  output logic                  err,
  output logic [7:0]            err_count
);

  localparam int SW = 7 + DIGITS;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]     CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);
  localparam logic [6:0]        SEG_BLANK = 7'h7F;

  // Returns {hit, nibble}. hit = 0 for any pattern outside the hex font.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0011000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = 5'b0;
    endcase
    return r;
  endfunction

  logic [SW-1:0]       sample_q, sample_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                fire_q, fire_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic                update_q, update_d;
  logic                err_q, err_d;
  logic [7:0]          errcnt_q, errcnt_d;

  logic [6:0]          acc_seg;
  logic [DIGITS-1:0]   acc_sel;
  logic [4:0]          dec;
  logic                sel_nz;
  logic                sel_oh;

  // Stability filter. The counter compares the incoming sample against the
  // registered one and saturates at the threshold. fire_q marks the single
  // cycle after the threshold was first reached. At that point sample_q still
  // holds the accepted pattern, because sample_q is only overwritten on the
  // same edge that consumes it.
  always_comb begin
    sample_d = {seg, dig_sel};
    cnt_d    = '0;
    if (sample_d == sample_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
    fire_d = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
  end

  assign acc_seg = sample_q[SW-1:DIGITS];
  assign acc_sel = sample_q[DIGITS-1:0];
  assign dec     = decode(acc_seg);
  assign sel_nz  = |acc_sel;
  // Clearing the lowest set bit leaves zero only for a single set bit.
  assign sel_oh  = sel_nz && ((acc_sel & (acc_sel - SEL_ONE)) == '0);

  always_comb begin
    value_d  = value_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;
    if (clr) begin
      // clr wins over a coinciding acceptance, which is dropped silently.
      valid_d  = '0;
      errcnt_d = '0;
    end else if (fire_q && sel_nz) begin
      if (!sel_oh) begin
        err_d    = 1'b1;
        errcnt_d = (errcnt_q == 8'hFF) ? errcnt_q : errcnt_q + 8'd1;
      end else if (acc_seg == SEG_BLANK) begin
        valid_d  = valid_q & ~acc_sel;
        update_d = 1'b1;
      end else if (dec[4]) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (acc_sel[i]) value_d[4*i +: 4] = dec[3:0];
        end
        valid_d  = valid_q | acc_sel;
        update_d = 1'b1;
      end else begin
        err_d    = 1'b1;
        errcnt_d = (errcnt_q == 8'hFF) ? errcnt_q : errcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= {SEG_BLANK, {DIGITS{1'b0}}};
      cnt_q    <= '0;
      fire_q   <= 1'b0;
      value_q  <= '0;
      valid_q  <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      fire_q   <= fire_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign update      = update_q;
  assign err         = err_q;
  assign err_count   = errcnt_q;

endmodule
